// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature poller.
// Holds the FSM state encoding and the sensor data format.
package temp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT_BUSY,
      WAIT_DONE,
      CAPTURE
   } state_t;

   localparam logic [7:0] CMD_DEFAULT = 8'h50;

   // 0.0625 C per LSB, kept as micro-degrees to stay integer
   localparam int TEMP_LSB_UC = 62500;

   typedef logic signed [12:0] temp_t;

endpackage

// File: rtl/temp_poller_if.sv
// Bus between the poller and the spi master beside it.
// The poller drives the request side, spi answers.
interface temp_poller_if #(
   parameter int BUFFER_BYTES = 4
) ();

   logic                          start_trans;
   logic                          trans_done;
   logic [BUFFER_BYTES*8-1:0]     in_bytes;
   logic [$clog2(BUFFER_BYTES):0] in_bytes_count;
   logic [$clog2(BUFFER_BYTES):0] out_bytes_count;
   logic [BUFFER_BYTES*8-1:0]     out_bytes;

   modport master (
      output start_trans,
      output in_bytes,
      output in_bytes_count,
      output out_bytes_count,
      input  trans_done,
      input  out_bytes
   );

   modport slave (
      input  start_trans,
      input  in_bytes,
      input  in_bytes_count,
      input  out_bytes_count,
      output trans_done,
      output out_bytes
   );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Reset value is a parameter so idle-high lines stay idle.
module sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // shift the level through two flops
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/temp_poller.sv
// Periodic temperature poller driving a toggle-start spi master.
// Sends one read command, captures the 13-bit reading.
module temp_poller
   import temp_pkg::*;
#(
   parameter int         BUFFER_BYTES   = 4,
   parameter int         POLL_CYCLES    = 1000000,
   parameter int         TIMEOUT_CYCLES = 65536,
   parameter logic [7:0] CMD_BYTE       = CMD_DEFAULT
) (
   input  logic          clk_in,
   input  logic          rst_n,
   input  logic          enable,
   input  logic          trigger,
   temp_poller_if.master spi,
   output temp_t         temp_raw,
   output logic          temp_valid,
   output logic          busy,
   output logic          timeout_err
);

   localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int CW = $clog2(BUFFER_BYTES) + 1;
   localparam logic [PW-1:0] P_LAST = PW'(POLL_CYCLES - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [BUFFER_BYTES*8-1:0] TX = (BUFFER_BYTES*8)'(CMD_BYTE);

   state_t        state, state_nx;
   logic [PW-1:0] pcnt, pcnt_nx;
   logic [TW-1:0] tcnt, tcnt_nx;
   logic          start, start_nx;
   temp_t         raw_nx;
   logic          valid_nx;
   logic          err_nx;
   logic          done_s;
   logic          tmo;
   logic          unused_bits;

   assign spi.in_bytes        = TX;
   assign spi.in_bytes_count  = CW'(1);
   assign spi.out_bytes_count = CW'(2);
   assign spi.start_trans     = start;
   assign busy                = (state != IDLE);
   assign tmo                 = (tcnt == T_LAST);
   assign unused_bits         = ^spi.out_bytes;

   sync2 #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .d      (spi.trans_done),
      .q      (done_s)
   );

   // state, counters and registered outputs
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pcnt        <= '0;
         tcnt        <= '0;
         start       <= 1'b0;
         temp_raw    <= '0;
         temp_valid  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nx;
         pcnt        <= pcnt_nx;
         tcnt        <= tcnt_nx;
         start       <= start_nx;
         temp_raw    <= raw_nx;
         temp_valid  <= valid_nx;
         timeout_err <= err_nx;
      end
   end

   // poll sequencing: launch, follow spi idle level, capture
   always_comb begin
      state_nx = state;
      pcnt_nx  = pcnt;
      tcnt_nx  = tcnt;
      start_nx = start;
      raw_nx   = temp_raw;
      valid_nx = 1'b0;
      err_nx   = timeout_err;
      unique case (state)
         IDLE: begin
            tcnt_nx = '0;
            if (trigger || (enable && pcnt == P_LAST)) begin
               state_nx = ARM;
               pcnt_nx  = '0;
            end else if (enable) begin
               pcnt_nx = pcnt + 1'b1;
            end else begin
               pcnt_nx = '0;
            end
         end
         ARM: begin
            if (done_s) begin
               start_nx = ~start;
               state_nx = WAIT_BUSY;
               tcnt_nx  = '0;
            end else if (tmo) begin
               err_nx   = 1'b1;
               state_nx = IDLE;
            end else begin
               tcnt_nx = tcnt + 1'b1;
            end
         end
         WAIT_BUSY: begin
            if (!done_s) begin
               state_nx = WAIT_DONE;
               tcnt_nx  = '0;
            end else if (tmo) begin
               err_nx   = 1'b1;
               state_nx = IDLE;
            end else begin
               tcnt_nx = tcnt + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (done_s) begin
               state_nx = CAPTURE;
            end else if (tmo) begin
               err_nx   = 1'b1;
               state_nx = IDLE;
            end else begin
               tcnt_nx = tcnt + 1'b1;
            end
         end
         CAPTURE: begin
            raw_nx   = temp_t'(spi.out_bytes[15:3]);
            valid_nx = 1'b1;
            err_nx   = 1'b0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_temp_poller.sv
// Directed bench for temp_poller with a toggle-start spi model.
// Expected values below are worked out by hand from the timing.
module tb_temp_poller;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               enable = 1'b0;
   logic               trigger = 1'b0;
   logic signed [12:0] temp_raw;
   logic               temp_valid;
   logic               busy;
   logic               timeout_err;

   temp_poller_if #(.BUFFER_BYTES(4)) spi_bus ();

   temp_poller #(
      .BUFFER_BYTES   (4),
      .POLL_CYCLES    (100),
      .TIMEOUT_CYCLES (50),
      .CMD_BYTE       (8'h50)
   ) dut (
      .clk_in      (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .trigger     (trigger),
      .spi         (spi_bus.master),
      .temp_raw    (temp_raw),
      .temp_valid  (temp_valid),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   int        cyc = 0;
   int        tog_n = 0;
   int        tog_cyc = 0;
   int        val_n = 0;
   int        rise_cyc = 0;
   int        spi_cnt = 0;
   int        busy_len = 6;
   bit        stuck = 1'b0;
   logic      last = 1'b0;
   logic [31:0] resp = 32'h0000_0C80;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // spi model: acts 1 time unit after each rising edge
   initial begin
      spi_bus.trans_done = 1'b1;
      spi_bus.out_bytes  = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (temp_valid) val_n++;
         if (rst_n && spi_bus.start_trans != last) begin
            tog_n++;
            tog_cyc = cyc;
            if (!stuck) begin
               spi_cnt = busy_len;
               spi_bus.out_bytes = resp;
            end
         end
         last = spi_bus.start_trans;
         if (spi_cnt == 0 && !spi_bus.trans_done) rise_cyc = cyc;
         spi_bus.trans_done = (spi_cnt == 0);
         if (spi_cnt > 0) spi_cnt--;
      end
   end

   task automatic wait_valid(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         seen = temp_valid;
      end
      chk(tag, int'(seen), 1);
   endtask

   task automatic wait_tog(input string tag, output int t);
      int n0 = tog_n;
      for (int i = 0; i < 400 && tog_n == n0; i++) @(negedge clk);
      chk(tag, int'(tog_n != n0), 1);
      t = tog_cyc;
   endtask

   task automatic pulse_trig();
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      int t1, t2, v, n0, c0, i;

      idle(3);
      chk("rst_raw", int'(temp_raw), 0);
      chk("rst_valid", int'(temp_valid), 0);
      chk("rst_err", int'(timeout_err), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_start", int'(spi_bus.start_trans), 0);
      chk("in_bytes", int'(spi_bus.in_bytes), 32'h50);
      chk("in_count", int'(spi_bus.in_bytes_count), 1);
      chk("out_count", int'(spi_bus.out_bytes_count), 2);
      rst_n = 1'b1;
      idle(2);

      // manual trigger with enable low, re-trigger in WAIT_DONE
      pulse_trig();
      i = 0;
      while (spi_cnt != 2 && i < 100) begin
         @(negedge clk);
         i++;
      end
      chk("reach_wait_done", int'(spi_cnt == 2), 1);
      pulse_trig();
      idle(30);
      chk("trig_toggles", tog_n, 1);
      chk("trig_valids", val_n, 1);
      chk("trig_raw", int'(temp_raw), 400);
      chk("trig_busy", int'(busy), 0);
      idle(150);
      chk("disabled_toggles", tog_n, 1);

      // periodic polling: 100 idle cycles + 11-cycle transaction
      enable = 1'b1;
      wait_tog("tog_a", t1);
      n0 = val_n;
      wait_tog("tog_b", t2);
      chk("period_ab", t2 - t1, 111);
      t1 = t2;
      wait_tog("tog_c", t2);
      chk("period_bc", t2 - t1, 111);
      chk("valid_per_poll", val_n - n0, 2);
      chk("poll_raw", int'(temp_raw), 400);

      // negative reading
      wait_valid("valid_pre_neg");
      resp = 32'h0000_E700;
      wait_valid("valid_neg");
      chk("neg_raw", int'(temp_raw), -800);

      // trigger lands exactly on period expiry
      v = cyc;
      n0 = tog_n;
      idle(99);
      pulse_trig();
      idle(20);
      chk("coinc_toggles", tog_n - n0, 1);
      chk("coinc_time", tog_cyc - v, 101);
      wait_valid("coinc_valid");
      v = cyc;
      wait_tog("coinc_next", t2);
      chk("coinc_next_time", t2 - v, 101);

      // handshake timeout: spi never goes busy
      wait_valid("pre_tmo_valid");
      enable = 1'b0;
      stuck = 1'b1;
      idle(3);
      n0 = val_n;
      c0 = tog_n;
      pulse_trig();
      idle(50);
      chk("tmo_err_early", int'(timeout_err), 0);
      chk("tmo_busy_early", int'(busy), 1);
      @(negedge clk);
      chk("tmo_err", int'(timeout_err), 1);
      chk("tmo_busy", int'(busy), 0);
      chk("tmo_no_valid", val_n - n0, 0);
      chk("tmo_toggle", tog_n - c0, 1);
      chk("tmo_raw", int'(temp_raw), -800);

      // a completed capture clears the sticky error
      stuck = 1'b0;
      resp = 32'h0000_0C80;
      pulse_trig();
      wait_valid("clr_valid");
      chk("clr_err", int'(timeout_err), 0);
      chk("clr_raw", int'(temp_raw), 400);

      // reset in WAIT_DONE, next poll must wait for spi idle
      idle(3);
      busy_len = 20;
      pulse_trig();
      i = 0;
      while (spi_cnt != 12 && i < 100) begin
         @(negedge clk);
         i++;
      end
      chk("reach_wait_done2", int'(spi_cnt == 12), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_start", int'(spi_bus.start_trans), 0);
      chk("mid_rst_raw", int'(temp_raw), 0);
      chk("mid_rst_err", int'(timeout_err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n0 = tog_n;
      pulse_trig();
      idle(5);
      chk("arm_holds", tog_n - n0, 0);
      chk("arm_busy", int'(busy), 1);
      wait_tog("post_rst_tog", t2);
      chk("post_rst_delay", t2 - rise_cyc, 3);
      wait_valid("post_rst_valid");
      chk("post_rst_raw", int'(temp_raw), 400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
